// File: rtl/rv_branch_pkg.sv
// rv_branch_pkg: shared branch condition codes, predictor states and index-width helper
package rv_branch_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: one 2-bit saturating predictor counter with inc/dec enables
module sat_counter2
    import rv_branch_pkg::*;
#(
    parameter logic [1:0] CTR_INIT = CTR_WNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] ctr
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctr <= CTR_INIT;
        else
            ctr <= (inc && ctr != CTR_ST)  ? ctr + 2'd1 :
                   (dec && ctr != CTR_SNT) ? ctr - 2'd1 : ctr;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves RV32I conditional branches in EX and trains a 2-bit BHT
module branch_resolve_unit
    import rv_branch_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CTR_INIT    = CTR_WNT,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             br_taken,
    output logic             mispredict,
    output logic             illegal_br,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int IW = idx_w(BHT_ENTRIES);

    logic [1:0]    ctrs [BHT_ENTRIES];
    logic [IW-1:0] if_idx, ex_idx;
    logic          live, illegal, upd, taken, eq, lt, ltu;

    assign if_idx        = if_pc[IW+1:2];
    assign ex_idx        = ex_pc[IW+1:2];
    assign if_pred_taken = ctrs[if_idx][1];

    // a pending mispredict means the instruction now in EX is on the wrong path
    assign live    = ex_valid & ex_branch & ~mispredict;
    assign illegal = ex_funct3[2:1] == 2'b01;
    assign upd     = live & ~illegal;

    always_comb begin
        eq    = ex_rs1 == ex_rs2;
        lt    = $signed(ex_rs1) < $signed(ex_rs2);
        ltu   = ex_rs1 < ex_rs2;
        taken = (ex_funct3 == F3_BEQ)  ? eq   :
                (ex_funct3 == F3_BNE)  ? !eq  :
                (ex_funct3 == F3_BLT)  ? lt   :
                (ex_funct3 == F3_BGE)  ? !lt  :
                (ex_funct3 == F3_BLTU) ? ltu  :
                (ex_funct3 == F3_BGEU) ? !ltu : 1'b0;
    end

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
        sat_counter2 #(.CTR_INIT(CTR_INIT)) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc   (upd & taken & (ex_idx == IW'(g))),
            .dec   (upd & ~taken & (ex_idx == IW'(g))),
            .ctr   (ctrs[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_taken      <= 1'b0;
            mispredict    <= 1'b0;
            illegal_br    <= 1'b0;
            mispred_count <= '0;
        end else begin
            br_taken      <= upd & taken;
            mispredict    <= upd & (taken != ex_pred_taken);
            illegal_br    <= live & illegal;
            mispred_count <= (mispredict && mispred_count != '1) ? mispred_count + 1'b1 : mispred_count;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and randomized checks against a behavioural branch/BHT model
module tb_branch_resolve_unit;
    localparam int N  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic [31:0]   if_pc = '0, ex_rs1 = '0, ex_rs2 = '0, ex_pc = '0;
    logic          ex_valid = 1'b0, ex_branch = 1'b0, ex_pred_taken = 1'b0;
    logic [2:0]    ex_funct3 = '0;
    logic          if_pred_taken, br_taken, mispredict, illegal_br;
    logic [CW-1:0] mispred_count;

    int n_chk = 0, n_pass = 0;
    int m_bht [N];
    bit m_mp;
    int m_cnt, c0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(N), .CTR_INIT(2'b01), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .br_taken(br_taken), .mispredict(mispredict), .illegal_br(illegal_br),
        .mispred_count(mispred_count)
    );

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mreset();
        m_mp = 1'b0;
        m_cnt = 0;
        foreach (m_bht[i]) m_bht[i] = 1;
    endtask

    task automatic drive(input bit v, input bit b, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] bb, input logic [31:0] pc, input bit pred, input logic [31:0] ipc);
        ex_valid = v; ex_branch = b; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = bb;
        ex_pc = pc; ex_pred_taken = pred; if_pc = ipc;
    endtask

    task automatic cycle();
        bit live, ill, t, e_taken, e_mp, e_ill;
        #1;
        chk("if_pred", if_pred_taken, m_bht[idx(if_pc)] >= 2);
        live    = ex_valid && ex_branch && !m_mp;
        ill     = ex_funct3 == 3'd2 || ex_funct3 == 3'd3;
        t       = cond(ex_funct3, ex_rs1, ex_rs2);
        e_taken = live && !ill && t;
        e_mp    = live && !ill && (t != ex_pred_taken);
        e_ill   = live && ill;
        @(posedge clk);
        #1;
        if (live && !ill)
            m_bht[idx(ex_pc)] = t ? (m_bht[idx(ex_pc)] == 3 ? 3 : m_bht[idx(ex_pc)] + 1)
                                  : (m_bht[idx(ex_pc)] == 0 ? 0 : m_bht[idx(ex_pc)] - 1);
        if (m_mp && m_cnt < (1 << CW) - 1) m_cnt++;
        m_mp = e_mp;
        chk("br_taken", br_taken, e_taken);
        chk("mispredict", mispredict, e_mp);
        chk("illegal_br", illegal_br, e_ill);
        chk("mispred_count", mispred_count, m_cnt);
    endtask

    task automatic idle();
        drive(0, 0, 3'd0, 0, 0, 0, 0, if_pc);
        cycle();
    endtask

    initial begin
        logic [3:0] exp3;
        mreset();
        #10 reset = 1'b0;
        idle();

        // 1: async reset while a mispredict is pending
        drive(1, 1, 3'd0, 7, 7, 32'h0, 0, 32'h0); cycle(); idle();
        drive(1, 1, 3'd0, 7, 7, 32'h0, 1, 32'h0); cycle();
        chk("t1_trained", if_pred_taken, 1);
        drive(1, 1, 3'd1, 1, 2, 32'h0, 0, 32'h0); cycle();
        chk("t1_pending", mispredict, 1);
        reset = 1'b1;
        #1;
        chk("t1_rst_mp", mispredict, 0);
        chk("t1_rst_br", br_taken, 0);
        chk("t1_rst_ill", illegal_br, 0);
        chk("t1_rst_cnt", mispred_count, 0);
        for (int i = 0; i < N; i++) begin
            if_pc = 32'(i * 4);
            #1 chk("t1_rst_pred", if_pred_taken, 0);
        end
        mreset();
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
        @(negedge clk) reset = 1'b0;
        cycle();
        chk("t1_no_pulse", mispredict, 0);

        // 2: signed vs unsigned less-than
        drive(1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h10, 0, 32'h10); cycle();
        chk("t2_blt_taken", br_taken, 1);
        chk("t2_blt_mp", mispredict, 1);
        idle();
        drive(1, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h10, 0, 32'h10); cycle();
        chk("t2_bltu_taken", br_taken, 0);
        chk("t2_bltu_mp", mispredict, 0);

        // 3: counter training and aliasing
        exp3 = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 3'd0, 9, 9, 32'h40, exp3[k], 32'h40);
            #1 chk("t3_pred", if_pred_taken, exp3[k]);
            cycle(); idle();
        end
        chk("t3_final", if_pred_taken, 1);
        if_pc = 32'h80;
        #1 chk("t3_alias", if_pred_taken, 1);

        // 4: wrong-path branch after a mispredict is squashed
        c0 = m_cnt;
        drive(1, 1, 3'd1, 5, 6, 32'h104, 0, 32'h108); cycle();
        chk("t4_mp", mispredict, 1);
        drive(1, 1, 3'd0, 3, 3, 32'h108, 0, 32'h108); cycle();
        chk("t4_squash_mp", mispredict, 0);
        chk("t4_squash_br", br_taken, 0);
        chk("t4_cnt", mispred_count, c0 + 1);
        chk("t4_ctr", if_pred_taken, 0);

        // 5: illegal funct3, then same-index lookup during update
        drive(1, 1, 3'd3, 3, 3, 32'h20, 0, 32'h20); cycle();
        chk("t5_ill", illegal_br, 1);
        chk("t5_ill_mp", mispredict, 0);
        chk("t5_ill_ctr", if_pred_taken, 0);
        drive(1, 1, 3'd0, 3, 3, 32'h20, 0, 32'h20);
        #1 chk("t5_old_pred", if_pred_taken, 0);
        cycle();
        chk("t5_new_pred", if_pred_taken, 1);
        idle();

        // 6: mispredict counter saturation
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 3'd0, 4, 4, 32'h30, 0, 32'h30); cycle(); idle();
        end
        chk("t6_sat", mispred_count, 15);

        // randomized phase
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 3)) - 2;
            b = $urandom_range(0, 2) == 0 ? a : 32'($urandom_range(0, 3)) - 2;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  a, b, 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
